// File: rtl/seg_scan_display.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : seg_scan_display                                                |
// | Brief  : multiplexed seven-segment scanner with hex / serial BCD capture |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module seg_scan_display #(
    parameter int NDIG     = 8,
    parameter int SCAN_DIV = 100000,
    parameter int NSRC     = 4
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [32*NSRC-1:0]                        src_data,
    input  logic [$clog2((NSRC > 1) ? NSRC : 2)-1:0]  src_sel,
    input  logic [NSRC-1:0]                           dec_mode,
    input  logic                                      load_en,
    input  logic                                      blank_lz,
    output logic [7:0]                                seg,
    output logic [NDIG-1:0]                           an,
    output logic                                      busy,
    output logic                                      ovf
);
    localparam int c_SELW = $clog2((NSRC > 1) ? NSRC : 2);
    localparam int c_IDXW = $clog2((NDIG > 1) ? NDIG : 2);
    localparam int c_PREW = $clog2(SCAN_DIV);
    localparam int c_DW   = 4 * NDIG;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [31:0]         r_shadow;
    logic                r_shadow_dec;
    logic [c_DW-1:0]     r_bcd;
    logic [c_DW-1:0]     w_bcd_adj;
    logic                r_bcd_ovf;
    logic [4:0]          r_bit_cnt;
    logic [c_DW-1:0]     r_disp;
    logic                r_ovf;
    logic [c_PREW-1:0]   r_presc;
    logic [c_IDXW-1:0]   r_idx;
    logic [31:0]         w_sel_data;
    logic                w_sel_dec;
    logic [3:0]          w_nib;
    logic                w_hi_nz;
    logic [NDIG-1:0]     w_an;

    function automatic logic [7:0] f_seg7(input logic [3:0] nib);
        case (nib)
            4'h0: f_seg7 = 8'hC0;
            4'h1: f_seg7 = 8'hF9;
            4'h2: f_seg7 = 8'hA4;
            4'h3: f_seg7 = 8'hB0;
            4'h4: f_seg7 = 8'h99;
            4'h5: f_seg7 = 8'h92;
            4'h6: f_seg7 = 8'h82;
            4'h7: f_seg7 = 8'hF8;
            4'h8: f_seg7 = 8'h80;
            4'h9: f_seg7 = 8'h98;
            4'hA: f_seg7 = 8'h88;
            4'hB: f_seg7 = 8'h83;
            4'hC: f_seg7 = 8'hA7;
            4'hD: f_seg7 = 8'hA1;
            4'hE: f_seg7 = 8'h86;
            default: f_seg7 = 8'h8E;
        endcase
    endfunction

    // Out-of-range selects fall through to value 0 in hex mode.
    always_comb begin
        w_sel_data = '0;
        w_sel_dec  = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (src_sel == c_SELW'(k)) begin
                w_sel_data = src_data[32*k +: 32];
                w_sel_dec  = dec_mode[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (load_en) begin
                    w_state_nxt = w_sel_dec ? S_CONV : S_COMMIT;
                end
            end
            S_CONV: begin
                if (r_bit_cnt == 5'd31) begin
                    w_state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    for (genvar d = 0; d < NDIG; d++) begin : g_dd_adj
        assign w_bcd_adj[4*d +: 4] = (r_bcd[4*d +: 4] >= 4'd5) ?
                                     (r_bcd[4*d +: 4] + 4'd3) : r_bcd[4*d +: 4];
    end

    // A one leaving the top BCD digit means the value needs more than NDIG digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow     <= '0;
            r_shadow_dec <= 1'b0;
            r_bcd        <= '0;
            r_bcd_ovf    <= 1'b0;
            r_bit_cnt    <= '0;
            r_disp       <= '0;
            r_ovf        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load_en) begin
                        r_shadow     <= w_sel_data;
                        r_shadow_dec <= w_sel_dec;
                        r_bcd        <= '0;
                        r_bcd_ovf    <= 1'b0;
                        r_bit_cnt    <= '0;
                    end
                end
                S_CONV: begin
                    r_bcd     <= {w_bcd_adj[c_DW-2:0], r_shadow[31]};
                    r_bcd_ovf <= r_bcd_ovf | w_bcd_adj[c_DW-1];
                    r_shadow  <= {r_shadow[30:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                end
                S_COMMIT: begin
                    if (r_shadow_dec) begin
                        r_disp <= r_bcd;
                        r_ovf  <= r_bcd_ovf;
                    end else begin
                        r_disp <= r_shadow[c_DW-1:0];
                        r_ovf  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (r_presc == c_PREW'(SCAN_DIV - 1)) begin
            r_presc <= '0;
            r_idx   <= (r_idx == c_IDXW'(NDIG - 1)) ? '0 : r_idx + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    always_comb begin
        w_nib   = 4'd0;
        w_hi_nz = 1'b0;
        w_an    = '1;
        for (int d = 0; d < NDIG; d++) begin
            if (r_idx == c_IDXW'(d)) begin
                w_nib   = r_disp[4*d +: 4];
                w_an[d] = 1'b0;
            end
            if ((c_IDXW'(d) >= r_idx) && (r_disp[4*d +: 4] != 4'd0)) begin
                w_hi_nz = 1'b1;
            end
        end
    end

    assign an   = w_an;
    assign busy = (r_state != S_IDLE);
    assign ovf  = r_ovf;
    assign seg  = r_ovf                                        ? 8'hBF :
                  (blank_lz && (r_idx != '0) && !w_hi_nz)      ? 8'hFF :
                  f_seg7(w_nib);

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_display.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_seg_scan_display                                             |
// | Brief  : self-checking bench with arithmetic reference model             |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_seg_scan_display;
    localparam int NDIG     = 8;
    localparam int SCAN_DIV = 4;
    localparam int NSRC     = 4;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b1;
    logic [127:0] src_data = '0;
    logic [1:0]   src_sel  = '0;
    logic [3:0]   dec_mode = '0;
    logic         load_en  = 1'b0;
    logic         blank_lz = 1'b0;
    logic [7:0]   seg;
    logic [7:0]   an;
    logic         busy;
    logic         ovf;

    int           checks   = 0;
    int           failures = 0;
    logic [31:0]  m_disp   = '0;
    logic         m_ovf    = 1'b0;
    int unsigned  m_cnt;
    logic [7:0]   seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h98, 8'h88, 8'h83, 8'hA7, 8'hA1, 8'h86, 8'h8E};

    seg_scan_display #(.NDIG(NDIG), .SCAN_DIV(SCAN_DIV), .NSRC(NSRC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .src_data (src_data),
        .src_sel  (src_sel),
        .dec_mode (dec_mode),
        .load_en  (load_en),
        .blank_lz (blank_lz),
        .seg      (seg),
        .an       (an),
        .busy     (busy),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; the active digit is this divided down.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_cnt <= 0;
        else        m_cnt <= m_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int unsigned v);
        logic [31:0] r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] exp_seg(input int idx);
        int         msd = 0;
        logic [3:0] nib;
        if (m_ovf) return 8'hBF;
        for (int i = 0; i < NDIG; i++)
            if (m_disp[4*i +: 4] != 4'd0) msd = i;
        if (blank_lz && idx > msd) return 8'hFF;
        nib = m_disp[4*idx +: 4];
        return seg_tbl[nib];
    endfunction

    task automatic check_scan();
        int idx = int'((m_cnt / SCAN_DIV) % NDIG);
        logic [7:0] ean = ~(8'd1 << idx);
        chk($sformatf("an[slot%0d]", idx), 32'(an), 32'(ean));
        chk($sformatf("seg[slot%0d]", idx), 32'(seg), 32'(exp_seg(idx)));
    endtask

    task automatic scan_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            check_scan();
        end
    endtask

    task automatic load(input int sel, input logic [31:0] val, input bit dec, input bit scramble);
        int n_busy = dec ? 33 : 1;
        @(negedge clk);
        src_data[32*sel +: 32] = val;
        dec_mode[sel]          = dec;
        src_sel                = 2'(sel);
        load_en                = 1'b1;
        @(posedge clk);
        #1 load_en = 1'b0;
        for (int i = 0; i < n_busy; i++) begin
            @(negedge clk);
            chk($sformatf("busy_during_%0d", i), 32'(busy), 32'd1);
            check_scan();
            if (scramble && i < n_busy - 1) begin
                src_data = {$urandom, $urandom, $urandom, $urandom};
                src_sel  = 2'($urandom);
                dec_mode = 4'($urandom);
                load_en  = 1'($urandom);
            end else begin
                load_en  = 1'b0;
            end
        end
        @(posedge clk);
        if (dec && val > 32'd99999999) begin
            m_ovf = 1'b1;
        end else begin
            m_ovf  = 1'b0;
            m_disp = dec ? to_bcd(val) : val;
        end
        @(negedge clk);
        chk("busy_after", 32'(busy), 32'd0);
        chk("ovf", 32'(ovf), 32'(m_ovf));
        check_scan();
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #11;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_an", 32'(an), 32'hFE);
        chk("rst_seg", 32'(seg), 32'hC0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Hex capture, full scan twice.
        load(1, 32'h1234ABCD, 1'b0, 1'b0);
        scan_cycles(64);

        // Decimal capture with inputs scrambled during conversion.
        load(2, 32'd12345678, 1'b1, 1'b1);
        scan_cycles(32);

        load(3, 32'd100000000, 1'b1, 1'b0);
        scan_cycles(32);
        load(3, 32'd99999999, 1'b1, 1'b0);
        scan_cycles(32);

        // Leading-zero blanking.
        load(0, 32'h00000050, 1'b0, 1'b0);
        blank_lz = 1'b1;
        scan_cycles(32);
        blank_lz = 1'b0;
        scan_cycles(32);

        for (int r = 0; r < 8; r++) begin
            int          sel = int'($urandom_range(0, 3));
            bit          dec = 1'($urandom_range(0, 1));
            logic [31:0] val = (dec && $urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 99999999))
                                                                  : 32'($urandom);
            if ($urandom_range(0, 1) == 1) val = val & 32'h0000_0FFF;
            blank_lz = 1'($urandom_range(0, 1));
            load(sel, val, dec, 1'($urandom_range(0, 1)));
            scan_cycles(16);
        end

        // Reset in the middle of a decimal conversion.
        blank_lz = 1'b0;
        @(negedge clk);
        src_data[64 +: 32] = 32'd87654321;
        dec_mode[2]        = 1'b1;
        src_sel            = 2'd2;
        load_en            = 1'b1;
        @(posedge clk);
        #1 load_en = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        m_disp = '0;
        m_ovf  = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_an", 32'(an), 32'hFE);
        chk("midrst_seg", 32'(seg), 32'hC0);
        @(negedge clk) rst_n = 1'b1;
        load(0, 32'h00000007, 1'b0, 1'b0);
        scan_cycles(8);

        // load_en held high: second capture on the edge after COMMIT.
        @(negedge clk);
        src_data[31:0] = 32'hCAFE0123;
        dec_mode[0]    = 1'b0;
        src_sel        = 2'd0;
        load_en        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_busy0", 32'(busy), 32'd1);
        check_scan();
        src_data[31:0] = 32'h0BADF00D;
        @(negedge clk);
        chk("b2b_busy1", 32'(busy), 32'd0);
        m_disp = 32'hCAFE0123;
        check_scan();
        @(negedge clk);
        chk("b2b_busy2", 32'(busy), 32'd1);
        check_scan();
        load_en = 1'b0;
        @(negedge clk);
        chk("b2b_busy3", 32'(busy), 32'd0);
        m_disp = 32'h0BADF00D;
        check_scan();
        scan_cycles(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_display.md
SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 Parameter NDIG, default 8: number of seven-segment digits driven (1..8).
REQ-002 Parameter SCAN_DIV, default 100000: clk cycles per digit slot (>=2).
REQ-003 Parameter NSRC, default 4: number of 32-bit selectable data sources (1..8); SELW = max(1, clog2(NSRC)).
REQ-004 clk  in  1  single system clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 src_data  in  32*NSRC  source k occupies bits [32k+31:32k].
REQ-007 src_sel  in  SELW  selects the source captured on load.
REQ-008 dec_mode  in  NSRC  bit k=1: source k is shown in decimal; bit k=0: shown in hex.
REQ-009 load_en  in  1  request to capture the selected source.
REQ-010 blank_lz  in  1  enables leading-zero blanking.
REQ-011 seg  out  8  active-low segment pattern {dp,g..a}.
REQ-012 an  out  NDIG  active-low one-hot digit enable.
REQ-013 busy  out  1  high while a capture or conversion is in progress.
REQ-014 ovf  out  1  high when the committed decimal value exceeds NDIG digits.

Function
REQ-015 The FSM SHALL have three states: IDLE, CONV and COMMIT. busy = (state != IDLE).
REQ-016 In IDLE, when load_en=1 at a rising edge:
- Latch src_data[src_sel] and dec_mode[src_sel] into a shadow register.
- src_sel >= NSRC latches value 0 in hex mode.
REQ-017 Hex capture SHALL go IDLE->COMMIT. disp = low 4*NDIG bits of the value, ovf=0. Display changes at edge T+1 after the load edge T.
REQ-018 Decimal capture SHALL go IDLE->CONV and perform serial double-dabble over a 4*NDIG-bit BCD accumulator, one value bit per clock, MSB first, for exactly 32 cycles:
- Add 3 to every BCD digit >=5 before each shift.
- Any 1 shifted out of the top digit sets a sticky overflow bit.
REQ-019 After 32 CONV cycles the FSM SHALL go to COMMIT. disp and ovf update at edge T+33. COMMIT always returns to IDLE on the next edge.
REQ-020 load_en SHALL be ignored while busy=1; the shadow value is not disturbed by src_data or src_sel changes during CONV.
REQ-021 disp and ovf SHALL change only in COMMIT; the scan never shows a partial conversion.
REQ-022 The prescaler SHALL count 0..SCAN_DIV-1 and wrap. tick = (count == SCAN_DIV-1).
REQ-023 On tick, the digit index SHALL advance by one, wrapping from NDIG-1 to 0. It is independent of the FSM.
REQ-024 an SHALL drive bit idx low and all other bits high.
REQ-025 seg SHALL encode nibble disp[4*idx+3:4*idx] as: 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:98 A:88 B:83 C:A7 D:A1 E:86 F:8E (hex).
REQ-026 When ovf=1, seg SHALL be BF (dash) on every digit.
REQ-027 When blank_lz=1, ovf=0 and idx>0 with all disp nibbles at positions >= idx equal to 0, seg SHALL be FF. Digit 0 is never blanked.
REQ-028 seg and an SHALL be combinational from the registered idx, disp, ovf and blank_lz; no glitch from the FSM.

Reset
REQ-029 rst_n low SHALL asynchronously force:
- state=IDLE, shadow=0, BCD accumulator=0, disp=0, ovf=0
- prescaler=0, idx=0
- so busy=0, an=~1 (bit0 low), seg=C0.
REQ-030 Reset during CONV SHALL abort the conversion with no commit. After release, the FSM accepts a load on the first edge with load_en=1.

Verification (SCAN_DIV=4, NDIG=8, NSRC=4)
REQ-031 Source 1 = 0x1234ABCD, dec_mode[1]=0, load at T -> busy high for one cycle. The scan shows D,C,B,A,4,3,2,1 on digits 0..7, each digit active 4 clocks.
REQ-032 Source 2 = 12345678, dec_mode[2]=1, load at T -> busy high from T+1 through T+33. disp=0x12345678 at T+33; src_sel and data toggling during CONV has no effect.
REQ-033 Decimal value 100000000 -> ovf=1, all digits BF. Decimal value 99999999 -> ovf=0, disp=0x99999999.
REQ-034 Hex value 0x00000050 with blank_lz=1 -> digits 0,1 show C0 and 92; digits 2..7 show FF. With blank_lz=0, digits 2..7 show C0.
REQ-035 rst_n asserted 10 cycles into a decimal conversion -> immediate idle state and seg=C0, an=FE. After release, a new hex load of 0x7 commits in 1 cycle.
REQ-036 Back-to-back load_en held high -> a new capture starts on the edge after COMMIT. Scan idx wraps from 7 to 0 without skipping a slot.
